// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and P7 address-map constants for the load/store unit
package lsu_pkg;

  typedef enum logic [3:0] {
    LSU_NONE = 4'd0,
    LSU_LW   = 4'd1,
    LSU_LH   = 4'd2,
    LSU_LHU  = 4'd3,
    LSU_LB   = 4'd4,
    LSU_LBU  = 4'd5,
    LSU_SW   = 4'd6,
    LSU_SH   = 4'd7,
    LSU_SB   = 4'd8
  } lsu_op_t;

  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXC_ADES = 5'd5;

  localparam logic [31:0] DM_LIMIT = 32'h0000_3000;
  localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TC1_BASE = 32'h0000_7F10;
  localparam logic [31:0] INT_BASE = 32'h0000_7F20;
  localparam logic [31:0] TC_SPAN  = 32'd12;
  localparam logic [31:0] INT_SPAN = 32'd4;
  localparam logic [3:0]  TC_COUNT_OFS = 4'h8;

  function automatic logic op_is_load(input lsu_op_t op);
    return (op == LSU_LW) || (op == LSU_LH) || (op == LSU_LHU) ||
           (op == LSU_LB) || (op == LSU_LBU);
  endfunction

  function automatic logic op_is_store(input lsu_op_t op);
    return (op == LSU_SW) || (op == LSU_SH) || (op == LSU_SB);
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// rtl/lsu_load_ext.sv - byte/half lane select with sign or zero extension for W-stage load data
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  lsu_op_t     op,
  input  logic [1:0]  lo,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = 8'h00;
    sel_half = 16'h0000;
    data     = 32'h0000_0000;
    case (lo)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    sel_half = lo[1] ? word[31:16] : word[15:0];
    case (op)
      LSU_LW:  data = word;
      LSU_LH:  data = {{16{sel_half[15]}}, sel_half};
      LSU_LHU: data = {16'h0000, sel_half};
      LSU_LB:  data = {{24{sel_byte[7]}}, sel_byte};
      LSU_LBU: data = {24'h00_0000, sel_byte};
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// rtl/lsu_bus_master.sv - M-stage load/store bus initiator with AdEL/AdES and W load register
// Optional performance counters are built when LSU_PERF_CNT_EN is defined.
module lsu_bus_master
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  lsu_op_t     m_op,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_store_data,
  input  logic [31:0] m_pc,
  input  logic        flush,
  input  logic        w_en,
  input  logic [31:0] m_data_rdata,
  input  logic [31:0] tc0_rdata,
  input  logic [31:0] tc1_rdata,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_int_addr,
  output logic [3:0]  m_int_byteen,
  output logic        tc0_we,
  output logic        tc1_we,
  output logic [31:0] m_inst_addr,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
`ifdef LSU_PERF_CNT_EN
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_excs,
`endif
  output logic [31:0] w_load_data,
  output logic        w_load_valid
);

  logic        is_load, is_store, is_word, is_half, is_byte;
  logic        in_dm, in_tc0, in_tc1, in_int, in_tc;
  logic        misaligned, unmapped, tc_narrow, tc_count_wr;
  logic        load_ok, store_ok;
  logic [3:0]  lane_en;
  logic [31:0] rd_sel;

  logic [31:0] w_word_q, w_word_d;
  lsu_op_t     w_op_q, w_op_d;
  logic [1:0]  w_lo_q, w_lo_d;
  logic        w_valid_q, w_valid_d;

  always_comb begin
    is_load  = op_is_load(m_op);
    is_store = op_is_store(m_op);
    is_word  = (m_op == LSU_LW) || (m_op == LSU_SW);
    is_half  = (m_op == LSU_LH) || (m_op == LSU_LHU) || (m_op == LSU_SH);
    is_byte  = (m_op == LSU_LB) || (m_op == LSU_LBU) || (m_op == LSU_SB);

    in_dm  = m_addr < DM_LIMIT;
    in_tc0 = (m_addr >= TC0_BASE) && (m_addr < TC0_BASE + TC_SPAN);
    in_tc1 = (m_addr >= TC1_BASE) && (m_addr < TC1_BASE + TC_SPAN);
    in_int = (m_addr >= INT_BASE) && (m_addr < INT_BASE + INT_SPAN);
    in_tc  = in_tc0 || in_tc1;

    misaligned  = (is_word && (m_addr[1:0] != 2'b00)) || (is_half && m_addr[0]);
    unmapped    = !(in_dm || in_tc || in_int);
    tc_narrow   = in_tc && (is_half || is_byte);
    // Both timer bases are 16-byte aligned, so the low nibble is the register offset.
    tc_count_wr = in_tc && is_store && (m_addr[3:0] == TC_COUNT_OFS);

    exc_valid = m_valid && (m_op != LSU_NONE) &&
                (misaligned || unmapped || tc_narrow || tc_count_wr);
    exc_code  = exc_valid ? (is_store ? EXC_ADES : EXC_ADEL) : 5'd0;

    load_ok  = m_valid && is_load  && !exc_valid && !flush;
    store_ok = m_valid && is_store && !exc_valid && !flush;

    m_data_wdata = m_store_data;
    lane_en      = 4'b0000;
    case (m_op)
      LSU_SW: lane_en = 4'b1111;
      LSU_SH: begin
        lane_en      = 4'b0011 << {m_addr[1], 1'b0};
        m_data_wdata = {2{m_store_data[15:0]}};
      end
      LSU_SB: begin
        lane_en      = 4'b0001 << m_addr[1:0];
        m_data_wdata = {4{m_store_data[7:0]}};
      end
      default: lane_en = 4'b0000;
    endcase

    m_data_addr   = m_addr;
    m_int_addr    = m_addr;
    m_inst_addr   = m_pc;
    m_data_byteen = (store_ok && in_dm)  ? lane_en : 4'b0000;
    m_int_byteen  = (store_ok && in_int) ? lane_en : 4'b0000;
    tc0_we        = store_ok && in_tc0;
    tc1_we        = store_ok && in_tc1;

    if (in_dm)       rd_sel = m_data_rdata;
    else if (in_tc0) rd_sel = tc0_rdata;
    else if (in_tc1) rd_sel = tc1_rdata;
    else             rd_sel = 32'h0000_0000;

    w_word_d  = w_word_q;
    w_op_d    = w_op_q;
    w_lo_d    = w_lo_q;
    w_valid_d = w_valid_q;
    if (w_en) begin
      w_word_d  = rd_sel;
      w_op_d    = m_op;
      w_lo_d    = m_addr[1:0];
      w_valid_d = load_ok;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_word_q  <= 32'h0000_0000;
      w_op_q    <= LSU_NONE;
      w_lo_q    <= 2'b00;
      w_valid_q <= 1'b0;
    end else begin
      w_word_q  <= w_word_d;
      w_op_q    <= w_op_d;
      w_lo_q    <= w_lo_d;
      w_valid_q <= w_valid_d;
    end
  end

  lsu_load_ext u_load_ext (
    .word (w_word_q),
    .op   (w_op_q),
    .lo   (w_lo_q),
    .data (w_load_data)
  );

  assign w_load_valid = w_valid_q;

`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_loads_q, perf_loads_d;
  logic [31:0] perf_stores_q, perf_stores_d;
  logic [31:0] perf_excs_q, perf_excs_d;

  always_comb begin
    perf_loads_d  = perf_loads_q;
    perf_stores_d = perf_stores_q;
    perf_excs_d   = perf_excs_q;
    if (w_en) begin
      if (load_ok)   perf_loads_d  = perf_loads_q + 32'd1;
      if (store_ok)  perf_stores_d = perf_stores_q + 32'd1;
      if (exc_valid) perf_excs_d   = perf_excs_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_loads_q  <= 32'd0;
      perf_stores_q <= 32'd0;
      perf_excs_q   <= 32'd0;
    end else begin
      perf_loads_q  <= perf_loads_d;
      perf_stores_q <= perf_stores_d;
      perf_excs_q   <= perf_excs_d;
    end
  end

  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
  assign perf_excs   = perf_excs_q;
`endif

endmodule

// File: tb/tb_lsu_bus_master.sv
// tb/tb_lsu_bus_master.sv - directed self-checking bench for lsu_bus_master
module tb_lsu_bus_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  lsu_op_t     m_op;
  logic [31:0] m_addr, m_store_data, m_pc;
  logic        flush, w_en;
  logic [31:0] m_data_rdata, tc0_rdata, tc1_rdata;
  logic [31:0] m_data_addr, m_data_wdata, m_int_addr, m_inst_addr, w_load_data;
  logic [3:0]  m_data_byteen, m_int_byteen;
  logic        tc0_we, tc1_we, exc_valid, w_load_valid;
  logic [4:0]  exc_code;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_loads, perf_stores, perf_excs;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_bus_master dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_op(m_op), .m_addr(m_addr),
    .m_store_data(m_store_data), .m_pc(m_pc), .flush(flush), .w_en(w_en),
    .m_data_rdata(m_data_rdata), .tc0_rdata(tc0_rdata), .tc1_rdata(tc1_rdata),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen), .tc0_we(tc0_we), .tc1_we(tc1_we),
    .m_inst_addr(m_inst_addr), .exc_valid(exc_valid), .exc_code(exc_code),
`ifdef LSU_PERF_CNT_EN
    .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_excs(perf_excs),
`endif
    .w_load_data(w_load_data), .w_load_valid(w_load_valid)
  );

  // Apply one M-stage op on the falling edge and let combinational outputs settle.
  task automatic drive(input logic v, input lsu_op_t op, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd, input logic fl,
                       input logic we);
    @(negedge clk);
    m_valid = v; m_op = op; m_addr = a; m_store_data = d;
    m_data_rdata = rd; flush = fl; w_en = we; m_pc = a + 32'h0040_0000;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_valid = 1'b0; m_op = LSU_NONE; m_addr = 32'h0; m_store_data = 32'h0; m_pc = 32'h0;
    flush = 1'b0; w_en = 1'b1; m_data_rdata = 32'h0;
    tc0_rdata = 32'hC0C0_0001; tc1_rdata = 32'hC1C1_0002;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (w_load_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", w_load_valid); end
    checks++; if (w_load_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", w_load_data); end
    checks++; if ({m_data_byteen, m_int_byteen, tc0_we, tc1_we} !== 10'b0) begin
      errors++; $display("FAIL reset_strobes got %b exp 0", {m_data_byteen, m_int_byteen, tc0_we, tc1_we}); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_byte_half();
    drive(1, LSU_SB, 32'h0000_0103, 32'h1234_56A5, 32'h0, 0, 1);
    checks++; if (m_data_byteen !== 4'b1000) begin errors++; $display("FAIL sb_byteen got %b exp 1000", m_data_byteen); end
    checks++; if (m_data_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata got %h exp a5a5a5a5", m_data_wdata); end
    checks++; if (exc_valid !== 1'b0) begin errors++; $display("FAIL sb_exc got %b exp 0", exc_valid); end
    checks++; if (m_inst_addr !== 32'h0040_0103) begin errors++; $display("FAIL inst_addr got %h exp 00400103", m_inst_addr); end
    drive(1, LSU_LB, 32'h0000_0103, 32'h0, 32'hA500_0000, 0, 1);
    after_edge();
    checks++; if (w_load_data !== 32'hFFFF_FFA5) begin errors++; $display("FAIL lb_data got %h exp ffffffa5", w_load_data); end
    checks++; if (w_load_valid !== 1'b1) begin errors++; $display("FAIL lb_valid got %b exp 1", w_load_valid); end
    drive(1, LSU_LBU, 32'h0000_0103, 32'h0, 32'hA500_0000, 0, 1);
    after_edge();
    checks++; if (w_load_data !== 32'h0000_00A5) begin errors++; $display("FAIL lbu_data got %h exp 000000a5", w_load_data); end
    drive(1, LSU_LB, 32'h0000_0101, 32'h0, 32'h0000_7F00, 0, 1);
    after_edge();
    checks++; if (w_load_data !== 32'h0000_007F) begin errors++; $display("FAIL lb_pos got %h exp 0000007f", w_load_data); end
    drive(1, LSU_LH, 32'h0000_0102, 32'h0, 32'h80A5_0000, 0, 1);
    after_edge();
    checks++; if (w_load_data !== 32'hFFFF_80A5) begin errors++; $display("FAIL lh_data got %h exp ffff80a5", w_load_data); end
    drive(1, LSU_LHU, 32'h0000_0000, 32'h0, 32'h1234_8001, 0, 1);
    after_edge();
    checks++; if (w_load_data !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data got %h exp 00008001", w_load_data); end
    drive(1, LSU_SH, 32'h0000_0012, 32'hDEAD_BEEF, 32'h0, 0, 1);
    checks++; if (m_data_byteen !== 4'b1100) begin errors++; $display("FAIL sh_byteen got %b exp 1100", m_data_byteen); end
    checks++; if (m_data_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got %h exp beefbeef", m_data_wdata); end
  endtask

  task automatic test_misaligned();
    drive(1, LSU_LW, 32'h0000_0000, 32'h0, 32'h5555_AAAA, 0, 1);
    after_edge();
    drive(1, LSU_LW, 32'h0000_0002, 32'h0, 32'h0, 0, 1);
    checks++; if (exc_valid !== 1'b1) begin errors++; $display("FAIL lw_mis_exc got %b exp 1", exc_valid); end
    checks++; if (exc_code !== 5'd4) begin errors++; $display("FAIL lw_mis_code got %0d exp 4", exc_code); end
    checks++; if (m_data_byteen !== 4'b0) begin errors++; $display("FAIL lw_mis_byteen got %b exp 0", m_data_byteen); end
    after_edge();
    checks++; if (w_load_valid !== 1'b0) begin errors++; $display("FAIL lw_mis_wvalid got %b exp 0", w_load_valid); end
    drive(1, LSU_SH, 32'h0000_0011, 32'h0, 32'h0, 0, 1);
    checks++; if (exc_code !== 5'd5 || m_data_byteen !== 4'b0) begin
      errors++; $display("FAIL sh_mis got code %0d byteen %b exp 5 0000", exc_code, m_data_byteen); end
  endtask

  task automatic test_timer();
    drive(1, LSU_SW, 32'h0000_7F08, 32'h1, 32'h0, 0, 1);
    checks++; if (exc_valid !== 1'b1 || exc_code !== 5'd5) begin
      errors++; $display("FAIL tc_count_st got exc %b code %0d exp 1 5", exc_valid, exc_code); end
    checks++; if (tc0_we !== 1'b0) begin errors++; $display("FAIL tc_count_we got %b exp 0", tc0_we); end
    drive(1, LSU_SW, 32'h0000_7F04, 32'h1, 32'h0, 0, 1);
    checks++; if (tc0_we !== 1'b1 || exc_valid !== 1'b0) begin
      errors++; $display("FAIL tc0_st got we %b exc %b exp 1 0", tc0_we, exc_valid); end
    checks++; if (m_data_byteen !== 4'b0 || tc1_we !== 1'b0) begin
      errors++; $display("FAIL tc0_st_other got byteen %b tc1 %b exp 0 0", m_data_byteen, tc1_we); end
    drive(1, LSU_LH, 32'h0000_7F10, 32'h0, 32'h0, 0, 1);
    checks++; if (exc_valid !== 1'b1 || exc_code !== 5'd4) begin
      errors++; $display("FAIL tc1_lh got exc %b code %0d exp 1 4", exc_valid, exc_code); end
    drive(1, LSU_LW, 32'h0000_7F14, 32'h0, 32'h0, 0, 1);
    after_edge();
    checks++; if (w_load_data !== 32'hC1C1_0002 || w_load_valid !== 1'b1) begin
      errors++; $display("FAIL tc1_lw got %h v%b exp c1c10002 v1", w_load_data, w_load_valid); end
    drive(1, LSU_LW, 32'h0000_7F08, 32'h0, 32'h0, 0, 1);
    after_edge();
    checks++; if (w_load_data !== 32'hC0C0_0001) begin errors++; $display("FAIL tc0_count_ld got %h exp c0c00001", w_load_data); end
  endtask

  task automatic test_int_and_bounds();
    drive(1, LSU_SW, 32'h0000_7F20, 32'h7, 32'h0, 0, 1);
    checks++; if (m_int_byteen !== 4'b1111 || m_data_byteen !== 4'b0) begin
      errors++; $display("FAIL int_sw got int %b dm %b exp 1111 0000", m_int_byteen, m_data_byteen); end
    drive(1, LSU_SW, 32'h0000_3000, 32'h7, 32'h0, 0, 1);
    checks++; if (exc_valid !== 1'b1 || exc_code !== 5'd5) begin
      errors++; $display("FAIL dm_limit got exc %b code %0d exp 1 5", exc_valid, exc_code); end
    drive(1, LSU_SW, 32'h0000_2FFC, 32'h7, 32'h0, 0, 1);
    checks++; if (exc_valid !== 1'b0 || m_data_byteen !== 4'b1111) begin
      errors++; $display("FAIL dm_last got exc %b byteen %b exp 0 1111", exc_valid, m_data_byteen); end
    drive(1, LSU_LW, 32'h0000_7F24, 32'h0, 32'h0, 0, 1);
    checks++; if (exc_valid !== 1'b1 || exc_code !== 5'd4) begin
      errors++; $display("FAIL int_past got exc %b code %0d exp 1 4", exc_valid, exc_code); end
  endtask

  task automatic test_flush();
    drive(1, LSU_SH, 32'h0000_0010, 32'hFFFF, 32'h0, 1, 1);
    checks++; if ({m_data_byteen, m_int_byteen, tc0_we, tc1_we} !== 10'b0) begin
      errors++; $display("FAIL flush_strobes got %b exp 0", {m_data_byteen, m_int_byteen, tc0_we, tc1_we}); end
    drive(1, LSU_LW, 32'h0000_0020, 32'h0, 32'h1111_2222, 0, 1);
    after_edge();
    drive(1, LSU_LW, 32'h0000_0024, 32'h0, 32'h3333_4444, 1, 1);
    after_edge();
    checks++; if (w_load_valid !== 1'b0) begin errors++; $display("FAIL flush_load got %b exp 0", w_load_valid); end
  endtask

  task automatic test_hold_and_async_reset();
    drive(1, LSU_LW, 32'h0000_0040, 32'h0, 32'h1234_5678, 0, 1);
    after_edge();
    checks++; if (w_load_data !== 32'h1234_5678 || w_load_valid !== 1'b1) begin
      errors++; $display("FAIL lw_capture got %h v%b exp 12345678 v1", w_load_data, w_load_valid); end
    for (int i = 0; i < 3; i++) begin
      drive(1, LSU_LB, 32'h0000_0044, 32'h0, 32'h9999_0000 + i, 0, 0);
      after_edge();
      checks++; if (w_load_data !== 32'h1234_5678 || w_load_valid !== 1'b1) begin
        errors++; $display("FAIL hold_%0d got %h v%b exp 12345678 v1", i, w_load_data, w_load_valid); end
    end
    drive(1, LSU_LW, 32'h0000_0048, 32'h0, 32'hAAAA_BBBB, 0, 1);
    after_edge();
    #1;
    reset = 1'b1;
    #1;
    checks++; if (w_load_valid !== 1'b0 || w_load_data !== 32'h0) begin
      errors++; $display("FAIL async_reset got %h v%b exp 0 v0", w_load_data, w_load_valid); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_byte_half();
    test_misaligned();
    test_timer();
    test_int_and_bounds();
    test_flush();
    test_hold_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
